// File: rtl/cordic_sin_cos.sv
// ============================================================================
// Module   : cordic_sin_cos
// Purpose  : Iterative rotation-mode CORDIC producing Q1.14 sine/cosine of a
//            signed Q2.14 angle, one micro-rotation per clock.
//            Optional macro CORDIC_QUADRANT_FOLD_EN extends the valid range
//            to the full +/-2 rad input span.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_sin_cos #(
    parameter int ITER = 16,
    parameter int IW   = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] angle_radian,
    output logic               done,
    output logic signed [15:0] cos,
    output logic signed [15:0] sin
);

    localparam int CW = 5;
    localparam logic [CW-1:0]          ITER_LAST = CW'(ITER);
    localparam logic signed [IW-1:0]   K_INIT    = IW'(9949);
    localparam logic signed [IW-1:0]   SAT_POS   = IW'(16384);
    localparam logic signed [IW-1:0]   SAT_NEG   = -IW'(16384);
`ifdef CORDIC_QUADRANT_FOLD_EN
    localparam logic signed [IW-1:0]   HALF_PI   = IW'(25736);
    localparam logic signed [IW-1:0]   PI_VAL    = IW'(51472);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          i_q;
    logic signed [IW-1:0]   x_q, y_q, z_q;
    logic signed [IW-1:0]   x_d, y_d, z_d;
    logic signed [IW-1:0]   x_sh, y_sh, atan_i;
    logic signed [IW-1:0]   ang_ext, z_load, x_fin;
    logic                   neg_cos_q, neg_cos_load;
    logic                   done_q;
    logic signed [15:0]     cos_q, sin_q;

    function automatic logic signed [IW-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            5'd0:    atan_lut = IW'(12868);
            5'd1:    atan_lut = IW'(7596);
            5'd2:    atan_lut = IW'(4014);
            5'd3:    atan_lut = IW'(2037);
            5'd4:    atan_lut = IW'(1023);
            5'd5:    atan_lut = IW'(512);
            5'd6:    atan_lut = IW'(256);
            5'd7:    atan_lut = IW'(128);
            5'd8:    atan_lut = IW'(64);
            5'd9:    atan_lut = IW'(32);
            5'd10:   atan_lut = IW'(16);
            5'd11:   atan_lut = IW'(8);
            5'd12:   atan_lut = IW'(4);
            5'd13:   atan_lut = IW'(2);
            5'd14:   atan_lut = IW'(1);
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] c;
        if (v > SAT_POS)      c = SAT_POS;
        else if (v < SAT_NEG) c = SAT_NEG;
        else                  c = v;
        sat16 = c[15:0];
    endfunction

    // Direction follows the sign of the residual angle (z >= 0 rotates positive).
    always_comb begin
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_i = atan_lut(i_q);
        if (z_q[IW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
        end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
        end
    end

    always_comb begin
        ang_ext      = {{(IW-16){angle_radian[15]}}, angle_radian};
        z_load       = ang_ext;
        neg_cos_load = 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
        // Reflect angles beyond +/-pi/2 through +/-pi; cosine changes sign.
        if (ang_ext > HALF_PI) begin
            z_load       = PI_VAL - ang_ext;
            neg_cos_load = 1'b1;
        end else if (ang_ext < -HALF_PI) begin
            z_load       = -PI_VAL - ang_ext;
            neg_cos_load = 1'b1;
        end
`endif
        x_fin = neg_cos_q ? -x_q : x_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            neg_cos_q <= 1'b0;
            done_q    <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        i_q       <= '0;
                        x_q       <= K_INIT;
                        y_q       <= '0;
                        z_q       <= z_load;
                        neg_cos_q <= neg_cos_load;
                        done_q    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_q == ITER_LAST) begin
                        state_q <= S_DONE;
                        cos_q   <= sat16(x_fin);
                        sin_q   <= sat16(y_q);
                        done_q  <= 1'b1;
                    end else begin
                        x_q <= x_d;
                        y_q <= y_d;
                        z_q <= z_d;
                        i_q <= i_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done = done_q;
    assign cos  = cos_q;
    assign sin  = sin_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_sin_cos.sv
// ============================================================================
// Module   : tb_cordic_sin_cos
// Purpose  : Table-driven, scoreboard-checked bench for cordic_sin_cos.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_sin_cos;

    localparam int TOL     = 4;
    localparam int LAT     = 17;
    localparam int TIMEOUT = 60;

    logic               clk;
    logic               reset;
    logic               start;
    logic signed [15:0] angle;
    logic               done;
    logic signed [15:0] cos_w;
    logic signed [15:0] sin_w;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [15:0] ang;
        int                 ecos;
        int                 esin;
        bit                 mid_start;
    } vec_t;

    typedef struct {
        int ecos;
        int esin;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    cordic_sin_cos dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .angle_radian (angle),
        .done         (done),
        .cos          (cos_w),
        .sin          (sin_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v, input int tol);
        int diff;
        checks++;
        diff = act - exp_v;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp_v, tol);
        end
    endtask

    task automatic run_one(input string tag, input logic signed [15:0] a,
                           input int ec, input int es, input bit mid, input bit from_done);
        exp_t e;
        int   n;
        bit   got;
        @(negedge clk);
        start = 1'b1;
        angle = a;
        sb.push_back('{ec, es});
        @(posedge clk);
        #1;
        start = 1'b0;
        angle = ~a;
        if (from_done) chk({tag, "_done_drop"}, int'(done), 0, 0);
        n   = 0;
        got = 1'b0;
        while (n < TIMEOUT && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
            if (mid && n == 5) begin
                start = 1'b1;
                angle = 16'sd0;
            end
            if (mid && n == 6) start = 1'b0;
        end
        e = sb.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, n, LAT, 0);
        end else begin
            chk({tag, "_latency"}, n, LAT, 0);
            chk({tag, "_cos"}, int'(cos_w), e.ecos, TOL);
            chk({tag, "_sin"}, int'(sin_w), e.esin, TOL);
        end
    endtask

    initial begin
        vecs[0] = '{16'sd12867,   11585,  11585, 1'b0};
        vecs[1] = '{16'sd0,       16384,      0, 1'b0};
        vecs[2] = '{-16'sd8579,   14189,  -8192, 1'b0};
        vecs[3] = '{16'sd8579,    14189,   8192, 1'b0};
        vecs[4] = '{16'sd25736,       0,  16384, 1'b1};
        vecs[5] = '{-16'sd12867,  11585, -11585, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        angle = '0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk("rst_done", int'(done), 0, 0);
            chk("rst_cos",  int'(cos_w), 0, 0);
            chk("rst_sin",  int'(sin_w), 0, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_done", int'(done), 0, 0);
        chk("idle_cos",  int'(cos_w), 0, 0);

        for (int k = 0; k < 6; k++)
            run_one($sformatf("vec%0d", k), vecs[k].ang, vecs[k].ecos, vecs[k].esin,
                    vecs[k].mid_start, k > 0);

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        start = 1'b1;
        angle = 16'sd12867;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_done", int'(done), 0, 0);
        chk("async_rst_cos",  int'(cos_w), 0, 0);
        chk("async_rst_sin",  int'(sin_w), 0, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_idle_done", int'(done), 0, 0);
        chk("post_rst_idle_sin",  int'(sin_w), 0, 0);

        run_one("after_rst", 16'sd12867, 11585, 11585, 1'b0, 1'b0);

`ifdef CORDIC_QUADRANT_FOLD_EN
        run_one("fold_2rad", 16'sd32767, -6818, 14898, 1'b0, 1'b1);
`endif

        chk("sb_empty", sb.size(), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
